// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit.
//
// Multiplies and divides are multi-cycle operations. An accepted request
// captures both operands, holds busy high for MUL_CYCLES or DIV_CYCLES
// cycles, and writes HI/LO on the edge where busy falls. MTHI/MTLO write
// HI/LO directly at the accepting edge. Requests arriving while busy are
// dropped, not queued.
//
// Ports:
//   clk      - clock, all registers update on the rising edge
//   reset    - synchronous, active-high reset
//   start    - operation request, sampled at the rising edge
//   op       - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//              110/111 no-op
//   rs_data  - operand A (dividend / multiplicand / MTHI-MTLO source)
//   rt_data  - operand B (divisor / multiplier)
//   busy     - high while a multiply or divide is in flight
//   hi, lo   - HI and LO registers
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // 64-bit product; signed operands are sign-extended so the low 64 bits
    // of the unsigned product equal the two's-complement signed product.
    function automatic logic [63:0] mul_64(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        is_signed
    );
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        a_ext = {{32{is_signed & a[31]}}, a};
        b_ext = {{32{is_signed & b[31]}}, b};
        return a_ext * b_ext;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of
    // overflowing; the quotient sign is the XOR of the operand signs and the
    // remainder follows the dividend.
    function automatic logic [63:0] div_32(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        is_signed
    );
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] quo;
        logic [31:0] rem;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quo = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem = neg_a ? (32'd0 - r_mag) : r_mag;
        return {rem, quo};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [31:0]      opa_r;
    logic [31:0]      opa_next_s;
    logic [31:0]      opb_r;
    logic [31:0]      opb_next_s;
    logic [1:0]       opsel_r;       // [1]=divide, [0]=unsigned
    logic [1:0]       opsel_next_s;
    logic [31:0]      hi_r;
    logic [31:0]      hi_next_s;
    logic [31:0]      lo_r;
    logic [31:0]      lo_next_s;
    logic             busy_r;
    logic             busy_next_s;

    logic             accept_long_s;
    logic             done_s;
    logic [63:0]      mul_res_s;
    logic [63:0]      div_res_s;

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Multiply/divide request that will be taken this edge (op[2]=0 selects
    // MULT/MULTU/DIV/DIVU).
    assign accept_long_s = start & (state_r == ST_IDLE) & ~op[2];
    // Final busy cycle: the counter reaches zero on this edge.
    assign done_s        = (state_r == ST_RUN) & (cnt_r <= CNT_W'(1));

    assign mul_res_s = mul_64(opa_r, opb_r, ~opsel_r[0]);
    assign div_res_s = div_32(opa_r, opb_r, ~opsel_r[0]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_long_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: operand capture, counter, busy, HI/LO.
    always_comb begin
        cnt_next_s   = cnt_r;
        opa_next_s   = opa_r;
        opb_next_s   = opb_r;
        opsel_next_s = opsel_r;
        hi_next_s    = hi_r;
        lo_next_s    = lo_r;
        busy_next_s  = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opa_next_s   = rs_data;
                            opb_next_s   = rt_data;
                            opsel_next_s = op[1:0];
                            cnt_next_s   = MUL_LOAD;
                            busy_next_s  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_next_s   = rs_data;
                            opb_next_s   = rt_data;
                            opsel_next_s = op[1:0];
                            cnt_next_s   = DIV_LOAD;
                            busy_next_s  = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_next_s = rs_data;
                        end
                        OP_MTLO: begin
                            lo_next_s = rs_data;
                        end
                        default: begin
                            // 110/111: no-op, hold everything
                            busy_next_s = 1'b0;
                        end
                    endcase
                end else begin
                    busy_next_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (done_s) begin
                    cnt_next_s  = '0;
                    busy_next_s = 1'b0;
                    if (opsel_r[1]) begin
                        // A zero divisor leaves HI/LO untouched.
                        if (opb_r != 32'd0) begin
                            hi_next_s = div_res_s[63:32];
                            lo_next_s = div_res_s[31:0];
                        end else begin
                            hi_next_s = hi_r;
                            lo_next_s = lo_r;
                        end
                    end else begin
                        hi_next_s = mul_res_s[63:32];
                        lo_next_s = mul_res_s[31:0];
                    end
                end else begin
                    cnt_next_s  = cnt_r - CNT_W'(1);
                    busy_next_s = 1'b1;
                end
            end
            default: begin
                cnt_next_s  = '0;
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset wins over start and over completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= '0;
            opa_r   <= 32'd0;
            opb_r   <= 32'd0;
            opsel_r <= 2'b00;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            opa_r   <= opa_next_s;
            opb_r   <= opb_next_s;
            opsel_r <= opsel_next_s;
            hi_r    <= hi_next_s;
            lo_r    <= lo_next_s;
            busy_r  <= busy_next_s;
        end
    end

endmodule
